tile_router_v2_00_a_input_port: RTL and testbench

Parametrised input port for the tile router: accepts packets from one neighbour link or local PE, tags PE-originated packets, computes the XY dimension-order route at enqueue, and buffers packet plus route in a C_FIFO_DEPTH-entry FIFO. The FIFO head is presented to up to 8 output clients. Unlike v1, it has configurable depth, full-throughput streaming with no bubble, and counting of misrouted drops. One instance sits per port inside the tile router, feeding the output-port arbiters.

---
 rtl/tile_router_v2_00_a_pkg.sv | 45 ++++
 rtl/tile_router_v2_00_a_route_calc.sv | 59 +++++
 rtl/tile_router_v2_00_a_input_port.sv | 120 ++++++++++++
 tb/tb_tile_router_v2_00_a_input_port.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_router_v2_00_a_pkg.sv
// ---------------------------------------------------------------------------
// tile_router_v2_00_a_pkg
// Shared definitions for the tile router input port:
//   - port identity codes (PE0..PE3, NORTH, EAST, SOUTH, WEST)
//   - one-hot route vectors, one bit per port identity
//   - packet header field positions (destination X/Y, source/destination PE)
//   - helper returning the mask of route bits that map to real clients
// Header layout (LSB first): [2:0] SRC_DST_PE, [6:3] DST_Y, [10:7] DST_X.
// ---------------------------------------------------------------------------
package tile_router_v2_00_a_pkg;

  typedef enum logic [2:0] {
    PORT_TYPE_PE0   = 3'd0,
    PORT_TYPE_PE1   = 3'd1,
    PORT_TYPE_PE2   = 3'd2,
    PORT_TYPE_PE3   = 3'd3,
    PORT_TYPE_NORTH = 3'd4,
    PORT_TYPE_EAST  = 3'd5,
    PORT_TYPE_SOUTH = 3'd6,
    PORT_TYPE_WEST  = 3'd7
  } port_type_e;

  localparam logic [7:0] ROUTE_VECTOR_PE0   = 8'h01;
  localparam logic [7:0] ROUTE_VECTOR_PE1   = 8'h02;
  localparam logic [7:0] ROUTE_VECTOR_PE2   = 8'h04;
  localparam logic [7:0] ROUTE_VECTOR_PE3   = 8'h08;
  localparam logic [7:0] ROUTE_VECTOR_NORTH = 8'h10;
  localparam logic [7:0] ROUTE_VECTOR_EAST  = 8'h20;
  localparam logic [7:0] ROUTE_VECTOR_SOUTH = 8'h40;
  localparam logic [7:0] ROUTE_VECTOR_WEST  = 8'h80;

  localparam int ROUTE_WIDTH         = 8;
  localparam int ADDRESS_WIDTH       = 4;
  localparam int SRC_DST_PE_WIDTH    = 3;
  localparam int SRC_DST_PE_FIELD    = 0;  // LSB of SRC_DST_PE
  localparam int DST_ADDRESS_Y_FIELD = 3;  // LSB of DST_Y
  localparam int DST_ADDRESS_X_FIELD = 7;  // LSB of DST_X

  // Route bits below num_clients address a real client; the rest are misroutes.
  function automatic logic [ROUTE_WIDTH-1:0] client_mask(input int num_clients);
    if (num_clients >= ROUTE_WIDTH) return '1;
    return ROUTE_WIDTH'((1 << num_clients) - 1);
  endfunction

endpackage

// File: rtl/tile_router_v2_00_a_route_calc.sv
// ---------------------------------------------------------------------------
// tile_router_v2_00_a_route_calc
// Purely combinational: tags PE-originated packets with the port identity,
// then computes the XY dimension-order one-hot route of the tagged packet.
// Ports:
//   payload         in  C_PACKET_WIDTH  incoming packet
//   tagged_payload  out C_PACKET_WIDTH  packet as it will be stored
//   route           out 8               one-hot destination port vector
// ---------------------------------------------------------------------------
module tile_router_v2_00_a_route_calc
  import tile_router_v2_00_a_pkg::*;
#(
  parameter int         C_PACKET_WIDTH = 66,
  parameter int         C_ADDRESS_X    = 0,
  parameter int         C_ADDRESS_Y    = 0,
  parameter port_type_e C_PORT_TYPE    = PORT_TYPE_EAST
) (
  input  logic [C_PACKET_WIDTH-1:0] payload,
  output logic [C_PACKET_WIDTH-1:0] tagged_payload,
  output logic [ROUTE_WIDTH-1:0]    route
);

  localparam logic IS_PE_PORT = (C_PORT_TYPE <= PORT_TYPE_PE3);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_X = ADDRESS_WIDTH'(C_ADDRESS_X);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_Y = ADDRESS_WIDTH'(C_ADDRESS_Y);

  logic                        x_match;
  logic                        y_match;
  logic [SRC_DST_PE_WIDTH-1:0] dst_pe;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    tagged_payload = payload;
    if (IS_PE_PORT)
      tagged_payload[SRC_DST_PE_FIELD +: SRC_DST_PE_WIDTH] = C_PORT_TYPE;
  end

  assign dst_pe  = tagged_payload[SRC_DST_PE_FIELD +: SRC_DST_PE_WIDTH];
  assign x_match = (tagged_payload[DST_ADDRESS_X_FIELD +: ADDRESS_WIDTH] == ADDR_X);
  assign y_match = (tagged_payload[DST_ADDRESS_Y_FIELD +: ADDRESS_WIDTH] == ADDR_Y);

  // Each port pairs with one PE and forwards along a fixed dimension order.
  always_comb begin
    route = '0;
    if (x_match && y_match) begin
      route = ROUTE_VECTOR_PE0 << dst_pe;
    end else begin
      case (C_PORT_TYPE)
        PORT_TYPE_EAST,  PORT_TYPE_PE0: route = x_match ? ROUTE_VECTOR_NORTH : ROUTE_VECTOR_WEST;
        PORT_TYPE_WEST,  PORT_TYPE_PE1: route = x_match ? ROUTE_VECTOR_SOUTH : ROUTE_VECTOR_EAST;
        PORT_TYPE_NORTH, PORT_TYPE_PE2: route = y_match ? ROUTE_VECTOR_EAST  : ROUTE_VECTOR_SOUTH;
        PORT_TYPE_SOUTH, PORT_TYPE_PE3: route = y_match ? ROUTE_VECTOR_WEST  : ROUTE_VECTOR_NORTH;
        default:                        route = '0;
      endcase
    end
  end

endmodule

// File: rtl/tile_router_v2_00_a_input_port.sv
// ---------------------------------------------------------------------------
// tile_router_v2_00_a_input_port
// One router input port: tags and routes each incoming packet, buffers packet
// plus route in a C_FIFO_DEPTH-entry FIFO, and presents the head packet to the
// output clients. Packets whose route names a non-existent client are accepted
// and dropped, and counted in a saturating misroute counter.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   input_valid      in   upstream packet valid
//   input_accept     out  port can take a packet this cycle
//   input_payload    in   upstream packet
//   clientX_valid    out  one-hot request to head packet's destination client
//   clientX_accept   in   per-client accept
//   clientX_payload  out  head packet replicated per client
//   fifo_count       out  occupied FIFO entries
//   misroute_count   out  saturating count of dropped packets
// ---------------------------------------------------------------------------
module tile_router_v2_00_a_input_port
  import tile_router_v2_00_a_pkg::*;
#(
  parameter int         C_NUM_CLIENTS  = 8,
  parameter int         C_PACKET_WIDTH = 66,
  parameter int         C_FIFO_DEPTH   = 4,
  parameter int         C_ADDRESS_X    = 0,
  parameter int         C_ADDRESS_Y    = 0,
  parameter port_type_e C_PORT_TYPE    = PORT_TYPE_EAST
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  input_valid,
  output logic                                  input_accept,
  input  logic [C_PACKET_WIDTH-1:0]             input_payload,
  output logic [C_NUM_CLIENTS-1:0]              clientX_valid,
  input  logic [C_NUM_CLIENTS-1:0]              clientX_accept,
  output logic [C_PACKET_WIDTH*C_NUM_CLIENTS-1:0] clientX_payload,
  output logic [$clog2(C_FIFO_DEPTH):0]         fifo_count,
  output logic [15:0]                           misroute_count
);

  localparam int PTR_W   = $clog2(C_FIFO_DEPTH);
  localparam int ENTRY_W = C_PACKET_WIDTH + ROUTE_WIDTH;
  localparam logic [ROUTE_WIDTH-1:0] CLIENT_MASK = client_mask(C_NUM_CLIENTS);
  localparam logic [PTR_W:0]         DEPTH       = (PTR_W+1)'(C_FIFO_DEPTH);

  logic [C_PACKET_WIDTH-1:0] tagged_payload;
  logic [ROUTE_WIDTH-1:0]    route;

  tile_router_v2_00_a_route_calc #(
    .C_PACKET_WIDTH (C_PACKET_WIDTH),
    .C_ADDRESS_X    (C_ADDRESS_X),
    .C_ADDRESS_Y    (C_ADDRESS_Y),
    .C_PORT_TYPE    (C_PORT_TYPE)
  ) u_route_calc (
    .payload        (input_payload),
    .tagged_payload (tagged_payload),
    .route          (route)
  );

  // Entry layout: {route, packet}
  logic [ENTRY_W-1:0]        mem [C_FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W:0]            count;
  logic [15:0]               misroute_cnt;

  logic                      handshake;
  logic                      misroute;
  logic                      push;
  logic                      pop;
  logic [ENTRY_W-1:0]        head;
  logic [ROUTE_WIDTH-1:0]    head_route;
  logic [C_PACKET_WIDTH-1:0] head_packet;

  // Accept depends on registered occupancy only: a full FIFO refuses input
  // even when the head is being popped in the same cycle.
  assign input_accept = !rst && (count < DEPTH);
  assign handshake    = input_valid && input_accept;
  assign misroute     = |(route & ~CLIENT_MASK);
  assign push         = handshake && !misroute;

  assign head        = mem[rd_ptr];
  assign head_route  = head[ENTRY_W-1 -: ROUTE_WIDTH];
  assign head_packet = head[C_PACKET_WIDTH-1:0];

  assign clientX_valid   = (count != '0) ? head_route[C_NUM_CLIENTS-1:0] : '0;
  assign clientX_payload = {C_NUM_CLIENTS{head_packet}};
  assign pop             = !rst && (|(clientX_valid & clientX_accept));

  // NOTE: the storage array has no reset; occupancy is tracked by count, so
  // stale entries are never presented and resetting the array would only add
  // a reset fan-out to every storage bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {route, tagged_payload};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misroute_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (handshake && misroute && (misroute_cnt != 16'hFFFF))
        misroute_cnt <= misroute_cnt + 16'd1;
    end
  end

  assign fifo_count     = count;
  assign misroute_count = misroute_cnt;

endmodule

// File: tb/tb_tile_router_v2_00_a_input_port.sv
// ---------------------------------------------------------------------------
// tb_tile_router_v2_00_a_input_port
// Three instances: EAST port at (1,1) with 8 clients, PE0 port at (1,1) with
// 8 clients, EAST port at (1,1) with 4 clients. Header layout: [2:0] PE,
// [6:3] DST_Y, [10:7] DST_X.
// ---------------------------------------------------------------------------
module tb_tile_router_v2_00_a_input_port;
  import tile_router_v2_00_a_pkg::*;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  // EAST, 8 clients
  logic         e_valid, e_accept;
  logic [65:0]  e_payload;
  logic [7:0]   e_cvalid, e_caccept;
  logic [527:0] e_cpayload;
  logic [2:0]   e_count;
  logic [15:0]  e_mis;

  // PE0, 8 clients
  logic         p_valid, p_accept;
  logic [65:0]  p_payload;
  logic [7:0]   p_cvalid, p_caccept;
  logic [527:0] p_cpayload;
  logic [2:0]   p_count;
  logic [15:0]  p_mis;

  // EAST, 4 clients
  logic         n_valid, n_accept;
  logic [65:0]  n_payload;
  logic [3:0]   n_cvalid, n_caccept;
  logic [263:0] n_cpayload;
  logic [2:0]   n_count;
  logic [15:0]  n_mis;

  tile_router_v2_00_a_input_port #(
    .C_NUM_CLIENTS(8), .C_PACKET_WIDTH(66), .C_FIFO_DEPTH(4),
    .C_ADDRESS_X(1), .C_ADDRESS_Y(1), .C_PORT_TYPE(PORT_TYPE_EAST)
  ) dut_east (
    .clk(clk), .rst(rst),
    .input_valid(e_valid), .input_accept(e_accept), .input_payload(e_payload),
    .clientX_valid(e_cvalid), .clientX_accept(e_caccept), .clientX_payload(e_cpayload),
    .fifo_count(e_count), .misroute_count(e_mis)
  );

  tile_router_v2_00_a_input_port #(
    .C_NUM_CLIENTS(8), .C_PACKET_WIDTH(66), .C_FIFO_DEPTH(4),
    .C_ADDRESS_X(1), .C_ADDRESS_Y(1), .C_PORT_TYPE(PORT_TYPE_PE0)
  ) dut_pe0 (
    .clk(clk), .rst(rst),
    .input_valid(p_valid), .input_accept(p_accept), .input_payload(p_payload),
    .clientX_valid(p_cvalid), .clientX_accept(p_caccept), .clientX_payload(p_cpayload),
    .fifo_count(p_count), .misroute_count(p_mis)
  );

  tile_router_v2_00_a_input_port #(
    .C_NUM_CLIENTS(4), .C_PACKET_WIDTH(66), .C_FIFO_DEPTH(4),
    .C_ADDRESS_X(1), .C_ADDRESS_Y(1), .C_PORT_TYPE(PORT_TYPE_EAST)
  ) dut_nc4 (
    .clk(clk), .rst(rst),
    .input_valid(n_valid), .input_accept(n_accept), .input_payload(n_payload),
    .clientX_valid(n_cvalid), .clientX_accept(n_caccept), .clientX_payload(n_cpayload),
    .fifo_count(n_count), .misroute_count(n_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [65:0] mk(input logic [3:0] x, input logic [3:0] y,
                                     input logic [2:0] pe, input logic [54:0] d);
    return {d, x, y, pe};
  endfunction

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({e_accept, p_accept, n_accept} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_accept_low: got %b expected 000", {e_accept, p_accept, n_accept});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({e_accept, p_accept, n_accept} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_accept_after: got %b expected 111", {e_accept, p_accept, n_accept});
    end
    n_checks++;
    if ({e_count, p_count, n_count} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %h %h %h expected 0", e_count, p_count, n_count);
    end
    n_checks++;
    if ({e_cvalid, p_cvalid, n_cvalid} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_valid: got %h %h %h expected 0", e_cvalid, p_cvalid, n_cvalid);
    end
    n_checks++;
    if ({e_mis, p_mis, n_mis} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_misroute: got %h %h %h expected 0", e_mis, p_mis, n_mis);
    end
  endtask

  // EAST port: local delivery, then the two forwarding directions.
  task automatic test_east_routing();
    logic [65:0] pkt   [3];
    logic [7:0]  exp_v [3];
    pkt[0] = mk(4'd1, 4'd1, 3'd2, 55'h1234_5678);   exp_v[0] = 8'h04;
    pkt[1] = mk(4'd1, 4'd3, 3'd6, 55'h0abc_def0);   exp_v[1] = 8'h10;
    pkt[2] = mk(4'd2, 4'd1, 3'd1, 55'h7fff_0001);   exp_v[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      e_valid = 1'b1;
      e_payload = pkt[i];
      step();
      e_valid = 1'b0;
      n_checks++;
      if (e_cvalid !== exp_v[i]) begin
        n_fail++;
        $display("FAIL east_route[%0d]: got %h expected %h", i, e_cvalid, exp_v[i]);
      end
      n_checks++;
      if (e_cpayload !== {8{pkt[i]}}) begin
        n_fail++;
        $display("FAIL east_payload[%0d]: got %h expected %h", i, e_cpayload[65:0], pkt[i]);
      end
      // Unaccepted head must hold.
      step();
      n_checks++;
      if (e_cvalid !== exp_v[i] || e_count !== 3'd1) begin
        n_fail++;
        $display("FAIL east_hold[%0d]: got valid %h count %0d expected %h 1", i, e_cvalid, e_count, exp_v[i]);
      end
      e_caccept = (i == 2) ? 8'hFF : exp_v[i];
      step();
      e_caccept = 8'h00;
      n_checks++;
      if (e_cvalid !== 8'h00 || e_count !== 3'd0) begin
        n_fail++;
        $display("FAIL east_pop[%0d]: got valid %h count %0d expected 00 0", i, e_cvalid, e_count);
      end
    end
  endtask

  // PE0 port: source PE field overwritten with 0 before routing.
  task automatic test_pe_tagging();
    logic [65:0] pkt   [2];
    logic [65:0] tag   [2];
    logic [7:0]  exp_v [2];
    pkt[0] = mk(4'd3, 4'd1, 3'd3, 55'h55);   tag[0] = mk(4'd3, 4'd1, 3'd0, 55'h55);   exp_v[0] = 8'h80;
    pkt[1] = mk(4'd1, 4'd1, 3'd3, 55'h66);   tag[1] = mk(4'd1, 4'd1, 3'd0, 55'h66);   exp_v[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      p_valid = 1'b1;
      p_payload = pkt[i];
      step();
      p_valid = 1'b0;
      n_checks++;
      if (p_cvalid !== exp_v[i]) begin
        n_fail++;
        $display("FAIL pe_route[%0d]: got %h expected %h", i, p_cvalid, exp_v[i]);
      end
      n_checks++;
      if (p_cpayload !== {8{tag[i]}}) begin
        n_fail++;
        $display("FAIL pe_tag[%0d]: got %h expected %h", i, p_cpayload[65:0], tag[i]);
      end
      p_caccept = exp_v[i];
      step();
      p_caccept = 8'h00;
      n_checks++;
      if (p_count !== 3'd0) begin
        n_fail++;
        $display("FAIL pe_pop[%0d]: got count %0d expected 0", i, p_count);
      end
    end
  endtask

  // Fill to depth with clients stalled, then drain in order.
  task automatic test_fill_and_drain();
    logic [65:0] fp [6];
    for (int i = 0; i < 6; i++) fp[i] = mk(4'd1, 4'd1, 3'd1, 55'(200 + i));
    e_caccept = 8'h00;
    for (int i = 0; i < 6; i++) begin
      e_valid = 1'b1;
      e_payload = fp[i];
      #1;
      n_checks++;
      if (e_accept !== (i < 4)) begin
        n_fail++;
        $display("FAIL fill_accept[%0d]: got %b expected %b", i, e_accept, (i < 4));
      end
      step();
      n_checks++;
      if (e_count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
        n_fail++;
        $display("FAIL fill_count[%0d]: got %0d", i, e_count);
      end
    end
    e_valid = 1'b0;
    // Accepts on clients the head does not target are ignored.
    e_caccept = 8'hFD;
    step();
    n_checks++;
    if (e_count !== 3'd4 || e_cvalid !== 8'h02) begin
      n_fail++;
      $display("FAIL fill_ignore_accept: got count %0d valid %h expected 4 02", e_count, e_cvalid);
    end
    e_caccept = 8'h02;
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (e_cpayload[65:0] !== fp[j] || e_cvalid !== 8'h02) begin
        n_fail++;
        $display("FAIL drain_head[%0d]: got %h valid %h expected %h 02", j, e_cpayload[65:0], e_cvalid, fp[j]);
      end
      step();
      n_checks++;
      if (e_count !== 3'(3 - j)) begin
        n_fail++;
        $display("FAIL drain_count[%0d]: got %0d expected %0d", j, e_count, 3 - j);
      end
    end
    e_caccept = 8'h00;
    n_checks++;
    if (e_cvalid !== 8'h00) begin
      n_fail++;
      $display("FAIL drain_empty_valid: got %h expected 00", e_cvalid);
    end
  endtask

  // 4-client EAST port: routes to NORTH/WEST are dropped and counted.
  task automatic test_misroute();
    logic [65:0] good;
    n_valid = 1'b1;
    n_payload = mk(4'd2, 4'd1, 3'd1, 55'h11);
    #1;
    n_checks++;
    if (n_accept !== 1'b1) begin
      n_fail++;
      $display("FAIL misroute_accept: got %b expected 1", n_accept);
    end
    step();
    n_valid = 1'b0;
    n_checks++;
    if (n_count !== 3'd0 || n_mis !== 16'd1 || n_cvalid !== 4'h0) begin
      n_fail++;
      $display("FAIL misroute_west: got count %0d mis %0d valid %h expected 0 1 0", n_count, n_mis, n_cvalid);
    end
    good = mk(4'd1, 4'd1, 3'd3, 55'h22);
    n_valid = 1'b1;
    n_payload = good;
    step();
    n_payload = mk(4'd1, 4'd2, 3'd0, 55'h33);
    step();
    n_valid = 1'b0;
    n_checks++;
    if (n_count !== 3'd1 || n_mis !== 16'd2 || n_cvalid !== 4'h8) begin
      n_fail++;
      $display("FAIL misroute_north: got count %0d mis %0d valid %h expected 1 2 8", n_count, n_mis, n_cvalid);
    end
    n_checks++;
    if (n_cpayload !== {4{good}}) begin
      n_fail++;
      $display("FAIL misroute_good_payload: got %h expected %h", n_cpayload[65:0], good);
    end
    n_caccept = 4'h8;
    step();
    n_caccept = 4'h0;
    n_checks++;
    if (n_count !== 3'd0) begin
      n_fail++;
      $display("FAIL misroute_pop: got count %0d expected 0", n_count);
    end
  endtask

  // Back-to-back streaming with accept held high, then reset mid-stream.
  task automatic test_back_to_back();
    logic [65:0] sp;
    e_caccept = 8'h01;
    for (int i = 0; i < 16; i++) begin
      sp = mk(4'd1, 4'd1, 3'd0, 55'(1000 + i));
      e_valid = 1'b1;
      e_payload = sp;
      #1;
      n_checks++;
      if (e_accept !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_accept[%0d]: got %b expected 1", i, e_accept);
      end
      step();
      n_checks++;
      if (e_count !== 3'd1 || e_cvalid !== 8'h01 || e_cpayload[65:0] !== sp) begin
        n_fail++;
        $display("FAIL stream[%0d]: got count %0d valid %h head %h expected 1 01 %h", i, e_count, e_cvalid, e_cpayload[65:0], sp);
      end
    end
    e_payload = mk(4'd1, 4'd1, 3'd0, 55'd2000);
    rst = 1'b1;
    #1;
    n_checks++;
    if (e_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_rst_accept: got %b expected 0", e_accept);
    end
    step();
    n_checks++;
    if (e_count !== 3'd0 || e_cvalid !== 8'h00) begin
      n_fail++;
      $display("FAIL stream_rst: got count %0d valid %h expected 0 00", e_count, e_cvalid);
    end
    rst = 1'b0;
    e_valid = 1'b0;
    e_caccept = 8'h00;
    step();
    n_checks++;
    if (e_accept !== 1'b1 || e_count !== 3'd0) begin
      n_fail++;
      $display("FAIL stream_after_rst: got accept %b count %0d expected 1 0", e_accept, e_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    e_valid = 1'b0; e_payload = '0; e_caccept = '0;
    p_valid = 1'b0; p_payload = '0; p_caccept = '0;
    n_valid = 1'b0; n_payload = '0; n_caccept = '0;

    test_reset();
    test_east_routing();
    test_pe_tagging();
    test_fill_and_drain();
    test_misroute();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
